// File: rtl/agu_context_sequencer.sv
// Context-cache controller: streams config words into the cache, then walks the
// context pointer over base..end for a requested number of iterations.
module agu_context_sequencer #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [WIDTH:0] cfg_data,
  input  logic           cfg_last,
  output logic [WIDTH:0] cache_indata,
  output logic           cache_start,
  output logic [15:0]    cache_cp,
  output logic [AW:0]    loaded_cnt,
  input  logic           run_req,
  input  logic [AW-1:0]  run_base,
  input  logic [AW-1:0]  run_end,
  input  logic [15:0]    run_iter,
  input  logic           stall,
  output logic           run_busy,
  output logic           run_done,
  output logic           run_err
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]    r_state;
  logic [AW:0]   r_loaded;
  logic [AW-1:0] r_cp;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_end;
  logic [15:0]   r_iter;
  logic          r_err;

  logic          w_beat;
  logic          w_run_ok;
  logic [AW:0]   w_loaded_inc;

  assign cfg_ready    = (r_state == S_LOAD) && (r_loaded < FULL) && !RST;
  assign w_beat       = cfg_valid && cfg_ready;
  assign w_loaded_inc = r_loaded + (AW+1)'(1);
  assign w_run_ok     = (run_base <= run_end) && ({1'b0, run_end} < r_loaded) &&
                        (run_iter != 16'd0);

  // The cache writes on every cycle with start low, so start drops only on a real beat.
  assign cache_start  = !w_beat;
  assign cache_indata = cfg_data;
  assign cache_cp     = {{(16-AW){1'b0}}, r_cp};
  assign loaded_cnt   = r_loaded;
  assign run_busy     = (r_state == S_RUN);
  assign run_done     = (r_state == S_DONE);
  assign run_err      = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_LOAD;
      r_loaded <= '0;
      r_cp     <= '0;
      r_base   <= '0;
      r_end    <= '0;
      r_iter   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_beat) begin
            r_loaded <= w_loaded_inc;
            if (cfg_last || (w_loaded_inc == FULL))
              r_state <= S_READY;
          end
        end
        S_READY: begin
          if (run_req) begin
            if (w_run_ok) begin
              r_cp    <= run_base;
              r_base  <= run_base;
              r_end   <= run_end;
              r_iter  <= run_iter;
              r_state <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // The pointer never passes the latched end, so the increment cannot wrap.
          if (!stall) begin
            if (r_cp != r_end) begin
              r_cp <= r_cp + AW'(1);
            end else if (r_iter > 16'd1) begin
              r_iter <= r_iter - 16'd1;
              r_cp   <= r_base;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_READY;
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/agu_context_sequencer.md
Name: agu_context_sequencer

Overview:
- Controller for the AGU context cache. It streams configuration words into the cache during a load phase, then generates the cache context pointer (CP) for loop-structured execution: base..end, repeated N times.
- Sits between the configuration source / top-level controller and the context cache. It drives the cache's start, indata and CP inputs.

Parameters:
- WIDTH, 28, MSB index of a context word (word is WIDTH+1 bits, matching the cache).
- DEPTH, 64, number of cache entries.
- AW, 6, entry index width (log2 DEPTH).

Ports:
- CLK  input  1  clock, all logic on posedge.
- RST  input  1  synchronous active-high reset.
- cfg_valid  input  1  config word present.
- cfg_ready  output  1  sequencer accepts a config word this cycle.
- cfg_data  input  WIDTH+1  config word.
- cfg_last  input  1  marks the final config word.
- cache_indata  output  WIDTH+1  to cache indata; equals cfg_data (combinational).
- cache_start  output  1  to cache start; 0 only on an accepted beat (cache writes every cycle start==0).
- cache_cp  output  16  to cache CP; registered; bits 15:AW always 0.
- loaded_cnt  output  AW+1  number of words written since reset.
- run_req  input  1  start a loop run (sampled in READY only).
- run_base  input  AW  first entry of the loop body.
- run_end  input  AW  last entry of the loop body.
- run_iter  input  16  iteration count.
- stall  input  1  hold CP this cycle.
- run_busy  output  1  high in RUN.
- run_done  output  1  one-cycle pulse after the final pointer.
- run_err  output  1  one-cycle pulse on a rejected run_req.

Behaviour:
- Reset (RST=1 at posedge):
  - state=LOAD, loaded_cnt=0, cache_cp=0, iter_cnt=0.
  - run_busy=0, run_done=0, run_err=0.
  - While RST is high: cfg_ready=0 and cache_start=1, so no cache writes occur.
- Reset applies in any state. A run in progress is abandoned, with no run_done.
- The cache write pointer has no reset. After any mid-load RST, the system must also reset the cache. This block assumes the cache pointer equals loaded_cnt.
- States: LOAD, READY, RUN, DONE.
- LOAD:
  - cfg_ready = (loaded_cnt < DEPTH) and not RST.
  - Beat accepted = cfg_valid & cfg_ready. On a beat: cache_start=0 that cycle, and loaded_cnt increments at the edge.
  - Go to READY when an accepted beat has cfg_last=1, or when loaded_cnt reaches DEPTH.
  - With no beat, cache_start=1.
- READY, RUN and DONE: cfg_ready=0 and cache_start=1.
- READY:
  - run_req is valid iff run_base <= run_end, run_end < loaded_cnt, and run_iter != 0.
  - Valid run_req: cache_cp<=run_base, iter_cnt<=run_iter, go to RUN.
  - Invalid run_req: run_err=1 for the next cycle, stay in READY.
  - run_req is ignored in every other state.
- RUN (run_busy=1):
  - stall=1: cache_cp and iter_cnt hold.
  - Else if cache_cp != run_end (latched): cache_cp++.
  - Else if iter_cnt > 1: iter_cnt--, cache_cp<=base (latched).
  - Else: go to DONE, cache_cp holds at end.
  - run_base and run_end are latched at acceptance. Later input changes have no effect.
- DONE: run_done=1 for exactly one cycle, then READY. cache_cp holds.
- Latency:
  - The first pointer (base) appears on cache_cp one cycle after the accepting run_req edge.
  - The cache output is combinational on CP, so the context is valid in the same cycle.
- A run emits (end-base+1)*run_iter non-stalled pointer cycles.
- base==end: the single entry is repeated run_iter times.
- iter_cnt is 16-bit, so the maximum is 65535 iterations.
- No arithmetic overflow: cache_cp never exceeds run_end < DEPTH.

Test Plan:
- Reset, then 4 beats with cfg_last on the 4th and cfg_valid gaps between beats: cache_start is low exactly 4 cycles, loaded_cnt=4, state READY, cfg_ready=0.
- 64 beats without cfg_last: after the 64th, cfg_ready=0, loaded_cnt=64, state READY. A 65th cfg_valid produces no cache_start low.
- run_req base=1 end=3 iter=2: cache_cp = 1,2,3,1,2,3 on consecutive cycles, then run_done is one pulse and run_busy drops.
- Same run with stall high for 2 cycles when cache_cp=2: cache_cp reads 2,2,2 and the total run is 8 cycles.
- With loaded_cnt=4, run_req with end=4, or base=3 end=1, or iter=0: run_err pulses, cache_cp unchanged, state READY.
- RST asserted during RUN at cache_cp=2: next cycle cache_cp=0, run_busy=0, no run_done, loaded_cnt=0, state LOAD, cfg_ready=1.
